// File: rtl/ntt_fold_readout.sv
// ntt_fold_readout: reads the NTT product h[0..2P-2], folds it mod x^P-x-1,
// reduces mod Q and streams r[0..P-1] with index, busy and done.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle request, accepted only when idle
//   ntt_addr        NTT read address (data returns one cycle later)
//   ntt_dout        NTT read data for the previous cycle's address
//   busy            readout in progress
//   out_valid       out_idx/out_coef valid this cycle
//   out_idx         result index i
//   out_coef        r[i] in [0,Q)
//   done            one-cycle pulse after the last output
module ntt_fold_readout #(
    parameter int P  = 761,
    parameter int Q  = 4591,
    parameter int AW = 11,
    parameter int IW = 14,
    parameter int OW = 13,
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] ntt_addr,
    input  logic [IW-1:0] ntt_dout,
    output logic          busy,
    output logic          out_valid,
    output logic [CW-1:0] out_idx,
    output logic [OW-1:0] out_coef,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DRAIN
    } state_t;

    localparam logic [15:0] Q1 = 16'(Q);
    localparam logic [15:0] Q2 = 16'(2 * Q);
    localparam logic [15:0] Q4 = 16'(4 * Q);
    localparam logic [15:0] Q8 = 16'(8 * Q);

    state_t state, state_nxt;

    logic [CW-1:0] cnt;
    logic [CW-1:0] hcnt;
    logic          lo_d1, lo_d2;
    logic          hi_d1, hi_d2;
    logic          last_d1, last_d2;
    logic [IW-1:0] lo_q;
    logic [IW-1:0] b_q;
    logic [IW-1:0] din;
    logic [15:0]   sum;
    logic          v1;
    logic [15:0]   s1;
    logic [CW-1:0] idx1;
    logic          accept;
    logic          last_i;
    logic          empty;

    // Sum < 11Q: first stage strips 8Q and 4Q, second strips 2Q and Q.
    function automatic logic [15:0] red_hi(input logic [15:0] x);
        logic [15:0] y;
        y = x;
        if (y >= Q8) y = y - Q8;
        if (y >= Q4) y = y - Q4;
        return y;
    endfunction

    function automatic logic [OW-1:0] red_lo(input logic [15:0] x);
        logic [15:0] y;
        y = x;
        if (y >= Q2) y = y - Q2;
        if (y >= Q1) y = y - Q1;
        return OW'(y);
    endfunction

    // A start coinciding with done belongs to the finished run.
    assign accept = (state == S_IDLE) && start && !done;
    assign last_i = (cnt == CW'(P - 1));
    assign empty  = !(lo_d1 | lo_d2 | hi_d1 | hi_d2 | v1);

    // h[2P-1] does not exist; the dummy read at address 0 is zeroed.
    assign din = last_d2 ? '0 : ntt_dout;
    assign sum = 16'(lo_q) + 16'(din) + 16'(b_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_LO;
            S_LO:    state_nxt = S_HI;
            S_HI:    state_nxt = last_i ? S_DRAIN : S_LO;
            S_DRAIN: if (empty) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address generation and read-return tagging.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ntt_addr <= '0;
            cnt      <= '0;
            lo_d1    <= 1'b0;
            lo_d2    <= 1'b0;
            hi_d1    <= 1'b0;
            hi_d2    <= 1'b0;
            last_d1  <= 1'b0;
            last_d2  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            lo_d1   <= (state == S_LO);
            hi_d1   <= (state == S_HI);
            last_d1 <= (state == S_HI) && last_i;
            lo_d2   <= lo_d1;
            hi_d2   <= hi_d1;
            last_d2 <= last_d1;
            busy    <= (state != S_IDLE) && !((state == S_DRAIN) && empty);
            done    <= (state == S_DRAIN) && empty;
            unique case (state)
                S_IDLE: begin
                    ntt_addr <= '0;
                    if (accept) cnt <= '0;
                end
                S_LO: ntt_addr <= AW'(cnt);
                S_HI: begin
                    ntt_addr <= last_i ? '0 : AW'(cnt) + AW'(P);
                    cnt      <= cnt + CW'(1);
                end
                default: ntt_addr <= '0;
            endcase
        end
    end

    // Fold and two-stage reduction; b_q carries h[i+P] into output i+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q      <= '0;
            b_q       <= '0;
            hcnt      <= '0;
            v1        <= 1'b0;
            s1        <= '0;
            idx1      <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_coef  <= '0;
        end else begin
            if (accept) begin
                b_q  <= '0;
                hcnt <= '0;
            end
            if (lo_d2) lo_q <= ntt_dout;
            v1 <= hi_d2;
            if (hi_d2) begin
                s1   <= red_hi(sum);
                b_q  <= din;
                idx1 <= hcnt;
                hcnt <= hcnt + CW'(1);
            end
            out_valid <= v1;
            if (v1) begin
                out_coef <= red_lo(s1);
                out_idx  <= idx1;
            end
        end
    end

endmodule
